// File: rtl/cr16_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cr16_ctrl_pkg
// Shared definitions for the CR16-subset multicycle control unit:
//   - state_t       : control FSM state encoding (also exported on the debug port)
//   - opcode fields : major/ext constants for the instruction classes the
//                     controller decodes (R-type, LOAD, STOR, Jcond, Bcond, ...)
//   - cond codes    : Bcond/Jcond condition codes carried in the Rdst field
//   - flag indices  : bit positions inside alu_flags / psr, {N,Z,F,L,C}
//   - writes_psr()  : which arithmetic op codes latch the ALU flags
// -----------------------------------------------------------------------------
package cr16_ctrl_pkg;

    // Control FSM states. Encodings 5..7 are unused and recover to S_FETCH.
    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_LD_WAIT = 3'd3,
        S_LD_WB   = 3'd4
    } state_t;

    // Major opcode classes (opcode[7:4]).
    localparam logic [3:0] MAJ_RTYPE = 4'h0;
    localparam logic [3:0] MAJ_MEM   = 4'h4;  // LOAD / STOR / Jcond / misc NOP
    localparam logic [3:0] MAJ_CMPI  = 4'hB;
    localparam logic [3:0] MAJ_BCOND = 4'hC;

    // R-type extensions (opcode[3:0]) that never write a register.
    localparam logic [3:0] EXT_NOP = 4'h0;
    localparam logic [3:0] EXT_CMP = 4'hB;

    // Full opcodes inside the 0100 class.
    localparam logic [7:0] OP_LOAD  = 8'h40;
    localparam logic [7:0] OP_STOR  = 8'h44;
    localparam logic [7:0] OP_JCOND = 8'h4C;

    // Arithmetic op codes that latch the flags (ext for R-type, major for I-type).
    localparam logic [3:0] OPC_ADD  = 4'h5;
    localparam logic [3:0] OPC_ADDU = 4'h6;
    localparam logic [3:0] OPC_ADDC = 4'h7;
    localparam logic [3:0] OPC_SUB  = 4'h9;
    localparam logic [3:0] OPC_SUBC = 4'hA;
    localparam logic [3:0] OPC_CMP  = 4'hB;

    // Condition codes (Rdst field of Bcond / Jcond).
    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    // Flag bit positions, {N,Z,F,L,C} = [4:0].
    localparam int unsigned FLAG_N = 4;
    localparam int unsigned FLAG_Z = 3;
    localparam int unsigned FLAG_F = 2;
    localparam int unsigned FLAG_L = 1;
    localparam int unsigned FLAG_C = 0;

    // True for the op codes whose result flags are latched into the PSR.
    // The codes 0100 and 1100 never match, so a caller may pass the major
    // field of any non-R-type instruction without further filtering.
    function automatic logic writes_psr(input logic [3:0] code);
        return (code == OPC_ADD)  || (code == OPC_ADDU) || (code == OPC_ADDC) ||
               (code == OPC_SUB)  || (code == OPC_SUBC) || (code == OPC_CMP);
    endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// -----------------------------------------------------------------------------
// cr16_cond_eval
// Combinational evaluation of a Bcond/Jcond condition code against the
// latched processor status register.
//   cond [3:0] : condition code (Rdst field of the branch/jump instruction)
//   psr  [4:0] : latched flags {N,Z,F,L,C}
//   take       : 1 when the branch/jump should be taken
// -----------------------------------------------------------------------------
module cr16_cond_eval
    import cr16_ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] psr,
    output logic       take
);

    logic n_flag;
    logic z_flag;
    logic f_flag;
    logic l_flag;
    logic c_flag;

    assign n_flag = psr[FLAG_N];
    assign z_flag = psr[FLAG_Z];
    assign f_flag = psr[FLAG_F];
    assign l_flag = psr[FLAG_L];
    assign c_flag = psr[FLAG_C];

    always_comb begin
        take = 1'b0;
        case (cond)
            CC_EQ:   take =  z_flag;
            CC_NE:   take = !z_flag;
            CC_CS:   take =  c_flag;
            CC_CC:   take = !c_flag;
            CC_HI:   take =  l_flag;
            CC_LS:   take = !l_flag;
            CC_GT:   take =  n_flag;
            CC_LE:   take = !n_flag;
            CC_FS:   take =  f_flag;
            CC_FC:   take = !f_flag;
            CC_LO:   take = !l_flag && !z_flag;
            CC_HS:   take =  l_flag ||  z_flag;
            CC_LT:   take = !n_flag && !z_flag;
            CC_GE:   take =  n_flag ||  z_flag;
            CC_UC:   take = 1'b1;
            CC_NV:   take = 1'b0;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/cr16_control_fsm.sv
// -----------------------------------------------------------------------------
// cr16_control_fsm
// Multicycle control unit for the CR16-subset datapath. Sequences every
// instruction through FETCH -> DECODE -> EXEC (-> LD_WAIT -> LD_WB for LOAD),
// drives all datapath selects/enables from the current state and the IR
// opcode, and owns the processor status register.
//
// Ports:
//   clk         : system clock, rising edge
//   rst         : asynchronous active-low reset
//   opcode[7:0] : IR opcode, [7:4] major, [3:0] ext
//   rdst_idx    : IR Rdst field; condition code for Bcond/Jcond
//   rsrc_idx    : IR Rsrc field (LOAD destination register)
//   alu_flags   : live ALU flags {N,Z,F,L,C}
//   ien, pcen   : IR load enable, PC update enable
//   branch/jump : PC source when pcen (PC+disp / srcMux); never both set
//   imm_sel     : ALU B operand, 1 = immediate
//   addr_sel    : BRAM address, 1 = PC, 0 = Rdst register
//   wb_sel      : writeback bus, 1 = memory data, 0 = ALU
//   we_a        : BRAM port A write enable
//   mdr_en      : capture BRAM q_a into the memory data register
//   reg_en      : one-hot register file write enable
//   psr         : latched flags, same order as alu_flags
//   state       : current FSM state (debug)
// -----------------------------------------------------------------------------
module cr16_control_fsm
    import cr16_ctrl_pkg::*;
#(
    parameter int NREG = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      opcode,
    input  logic [3:0]      rdst_idx,
    input  logic [3:0]      rsrc_idx,
    input  logic [4:0]      alu_flags,
    output logic            ien,
    output logic            pcen,
    output logic            branch,
    output logic            jump,
    output logic            imm_sel,
    output logic            addr_sel,
    output logic            wb_sel,
    output logic            we_a,
    output logic            mdr_en,
    output logic [NREG-1:0] reg_en,
    output logic [4:0]      psr,
    output logic [2:0]      state
);

    state_t            cur_state;
    state_t            next_state;
    logic              psr_load;
    logic              take;
    logic [3:0]        major;
    logic [3:0]        ext;
    logic [3:0]        flag_code;
    logic [NREG-1:0]   rdst_onehot;
    logic [NREG-1:0]   rsrc_onehot;

    assign major = opcode[7:4];
    assign ext   = opcode[3:0];

    // R-type carries its arithmetic op in ext, I-type in major.
    assign flag_code = (major == MAJ_RTYPE) ? ext : major;

    assign rdst_onehot = {{(NREG-1){1'b0}}, 1'b1} << rdst_idx;
    assign rsrc_onehot = {{(NREG-1){1'b0}}, 1'b1} << rsrc_idx;

    assign state = cur_state;

    // Conditions read the latched PSR, so a compare followed directly by a
    // branch sees the compare's flags rather than whatever the ALU shows now.
    cr16_cond_eval u_cond_eval (
        .cond (rdst_idx),
        .psr  (psr),
        .take (take)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psr <= '0;
        end else if (psr_load) begin
            psr <= alu_flags;
        end
    end

    // NOTE: every output gets a default before the case, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        next_state = S_FETCH;
        psr_load   = 1'b0;
        ien        = 1'b0;
        pcen       = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        imm_sel    = 1'b0;
        addr_sel   = 1'b0;
        wb_sel     = 1'b0;
        we_a       = 1'b0;
        mdr_en     = 1'b0;
        reg_en     = '0;

        case (cur_state)
            S_FETCH: begin
                addr_sel   = 1'b1;
                next_state = S_DECODE;
            end

            S_DECODE: begin
                ien        = 1'b1;
                next_state = S_EXEC;
            end

            S_EXEC: begin
                next_state = S_FETCH;
                psr_load   = writes_psr(flag_code);
                case (major)
                    MAJ_RTYPE: begin
                        imm_sel = 1'b0;
                        pcen    = 1'b1;
                        if ((ext != EXT_NOP) && (ext != EXT_CMP)) begin
                            reg_en = rdst_onehot;
                        end
                    end

                    MAJ_MEM: begin
                        case (opcode)
                            OP_LOAD: begin
                                // Address comes from Rdst; the register write
                                // happens two cycles later in LD_WB.
                                addr_sel   = 1'b0;
                                next_state = S_LD_WAIT;
                            end
                            OP_STOR: begin
                                addr_sel = 1'b0;
                                we_a     = 1'b1;
                                pcen     = 1'b1;
                            end
                            OP_JCOND: begin
                                pcen = 1'b1;
                                jump = take;
                            end
                            default: begin
                                pcen = 1'b1;
                            end
                        endcase
                    end

                    MAJ_BCOND: begin
                        pcen   = 1'b1;
                        branch = take;
                    end

                    default: begin
                        imm_sel = 1'b1;
                        pcen    = 1'b1;
                        if (major != MAJ_CMPI) begin
                            reg_en = rdst_onehot;
                        end
                    end
                endcase
            end

            S_LD_WAIT: begin
                addr_sel   = 1'b0;
                mdr_en     = 1'b1;
                next_state = S_LD_WB;
            end

            S_LD_WB: begin
                wb_sel     = 1'b1;
                reg_en     = rsrc_onehot;
                pcen       = 1'b1;
                next_state = S_FETCH;
            end

            default: begin
                next_state = S_FETCH;
            end
        endcase
    end

endmodule
